// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single off-chip block memory port between the
// I-cache and the D-cache. Each grant is held until mem_ready, then one
// RELEASE cycle follows so the winner can drop or change its request.
module mem_arbiter #(
  parameter int ADDR_W     = 28,
  parameter int DATA_W     = 128,
  parameter int FIXED_PRIO = 0
) (
  input  logic              clk,
  input  logic              proc_reset,
  input  logic              ic_read,
  input  logic              ic_write,
  input  logic [ADDR_W-1:0] ic_addr,
  input  logic [DATA_W-1:0] ic_wdata,
  output logic [DATA_W-1:0] ic_rdata,
  output logic              ic_ready,
  input  logic              dc_read,
  input  logic              dc_write,
  input  logic [ADDR_W-1:0] dc_addr,
  input  logic [DATA_W-1:0] dc_wdata,
  output logic [DATA_W-1:0] dc_rdata,
  output logic              dc_ready,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  typedef enum logic [1:0] {IDLE, GNT_I, GNT_D, RELEASE} state_t;

  state_t              state_q, state_d;
  logic                last_d_q, last_d_d;   // 1: most recent grant went to D
  logic                wr_q, wr_d;
  logic                rd_q, rd_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;

  logic req_i, req_d, pick_d, gnt_d;

  // State register and latched transfer; reset comes up idle with D as
  // the previous winner so I takes the first tie.
  always_ff @(posedge clk) begin
    if (proc_reset) begin
      state_q  <= IDLE;
      last_d_q <= 1'b1;
      wr_q     <= 1'b0;
      rd_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      last_d_q <= last_d_d;
      wr_q     <= wr_d;
      rd_q     <= rd_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
    end
  end

  // Arbitration, next state and all outputs.
  always_comb begin
    state_d   = state_q;
    last_d_d  = last_d_q;
    wr_d      = wr_q;
    rd_d      = rd_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    ic_rdata  = '0;
    ic_ready  = 1'b0;
    dc_rdata  = '0;
    dc_ready  = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    req_i     = ic_read | ic_write;
    req_d     = dc_read | dc_write;
    // D wins when alone, when fixed priority is on, or when I won last time.
    pick_d    = req_d & (~req_i | (FIXED_PRIO != 0) | ~last_d_q);
    gnt_d     = (state_q == GNT_D);

    case (state_q)
      IDLE: begin
        if (req_i | req_d) begin
          // Write dominates if a client raises both strobes.
          wr_d     = pick_d ? dc_write : ic_write;
          rd_d     = ~wr_d;
          addr_d   = pick_d ? dc_addr  : ic_addr;
          wdata_d  = pick_d ? dc_wdata : ic_wdata;
          last_d_d = pick_d;
          state_d  = pick_d ? GNT_D : GNT_I;
        end
      end
      GNT_I, GNT_D: begin
        // Strobe falls in the ready cycle so memory never sees a second access.
        mem_read  = rd_q & ~mem_ready;
        mem_write = wr_q & ~mem_ready;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        if (mem_ready) begin
          ic_ready = ~gnt_d;
          dc_ready = gnt_d;
          ic_rdata = gnt_d ? '0 : mem_rdata;
          dc_rdata = gnt_d ? mem_rdata : '0;
          state_d  = RELEASE;
        end
      end
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: two arbiters (round-robin and fixed D priority) driven by
// random cache clients, a random-latency memory and random resets. A
// transfer-level model predicts each grant into a queue; a monitor pops the
// queue when the memory strobe appears and checks the whole transfer.
module tb_mem_arbiter;

  typedef struct {
    bit           d;
    bit           wr;
    logic [27:0]  addr;
    logic [127:0] wdata;
    int           cyc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_cmp = 0;
  int n_bad = 0;
  int done_cnt = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : h
    logic          proc_reset;
    logic          ic_read, ic_write, dc_read, dc_write;
    logic [27:0]   ic_addr, dc_addr, mem_addr;
    logic [127:0]  ic_wdata, dc_wdata, mem_wdata, ic_rdata, dc_rdata, mem_rdata;
    logic          ic_ready, dc_ready, mem_read, mem_write, mem_ready;

    mem_arbiter #(.ADDR_W(28), .DATA_W(128), .FIXED_PRIO(g)) dut (
      .clk(clk), .proc_reset(proc_reset),
      .ic_read(ic_read), .ic_write(ic_write), .ic_addr(ic_addr), .ic_wdata(ic_wdata),
      .ic_rdata(ic_rdata), .ic_ready(ic_ready),
      .dc_read(dc_read), .dc_write(dc_write), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
      .dc_rdata(dc_rdata), .dc_ready(dc_ready),
      .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    exp_t q[$];
    exp_t cur;
    bit   cur_act = 0;
    bit   started = 0;
    int   ms = 0;       // model phase: 0 free, 1 transfer open, 2 release
    bit   last = 1;     // model: previous winner was D
    bit   rst_s = 0, strb_s = 0, req_s = 0, busy = 0;
    int   cnt = 0;

    // Client and reset stimulus.
    initial begin
      int op;
      proc_reset = 1; ic_read = 0; ic_write = 0; dc_read = 0; dc_write = 0;
      ic_addr = '0; dc_addr = '0; ic_wdata = '0; dc_wdata = '0;
      repeat (3) @(posedge clk);
      #1 proc_reset = 0;
      started = 1;
      for (int i = 0; i < 4000; i++) begin
        bit sat;
        @(posedge clk); #1;
        sat = (i >= 1500 && i < 2500);
        proc_reset = (i < 3800) && ($urandom % 90 == 0);
        if (sat || $urandom % 6 == 0) begin
          op = $urandom % 8;
          if (op > 3) op = sat ? 1 : 0;
          if (sat && op == 0) op = 2;
          ic_read = op[0]; ic_write = op[1];
          ic_addr = 28'($urandom);
          ic_wdata = {$urandom, $urandom, $urandom, $urandom};
        end
        if (sat || $urandom % 6 == 0) begin
          op = $urandom % 8;
          if (op > 3) op = sat ? 1 : 0;
          if (sat && op == 0) op = 3;
          dc_read = op[0]; dc_write = op[1];
          dc_addr = 28'($urandom);
          dc_wdata = {$urandom, $urandom, $urandom, $urandom};
        end
      end
      @(posedge clk); #1;
      proc_reset = 0; ic_read = 0; ic_write = 0; dc_read = 0; dc_write = 0;
      repeat (40) @(posedge clk);
      chk("drain_queue_and_open_transfer", 128'({q.size() != 0, cur_act}), 128'(0));
      done_cnt++;
    end

    // Memory side sampling for the responder.
    always @(negedge clk) begin
      rst_s  = proc_reset;
      strb_s = mem_read | mem_write;
      req_s  = ic_read | ic_write | dc_read | dc_write;
    end

    // Memory responder: 1..5 cycle latency, plus stray ready pulses only in
    // cycles where no grant can be active (right after reset, or when idle).
    initial begin
      mem_ready = 0; mem_rdata = '0;
      forever begin
        @(posedge clk); #1;
        mem_rdata = {$urandom, $urandom, $urandom, $urandom};
        mem_ready = 0;
        if (rst_s) begin
          busy = 0;
          mem_ready = 1;
        end else begin
          if (!busy && strb_s) begin busy = 1; cnt = $urandom_range(0, 4); end
          if (busy) begin
            if (cnt == 0) begin mem_ready = 1; busy = 0; end
            else cnt--;
          end else if (!strb_s && !req_s && $urandom % 8 == 0) mem_ready = 1;
        end
      end
    end

    // Reference model: decides each grant from the arbitration rules and
    // predicts the first strobe one cycle later.
    always @(negedge clk) if (started) begin
      bit ri, rd, pd;
      exp_t e;
      ri = ic_read | ic_write;
      rd = dc_read | dc_write;
      case (ms)
        0: if (!proc_reset && (ri || rd)) begin
          pd = (ri && rd) ? ((g == 1) ? 1'b1 : !last) : rd;
          e.d     = pd;
          e.wr    = pd ? dc_write : ic_write;
          e.addr  = pd ? dc_addr : ic_addr;
          e.wdata = pd ? dc_wdata : ic_wdata;
          e.cyc   = cyc + 1;
          q.push_back(e);
          last = pd;
          ms = 1;
        end
        1: if (mem_ready) ms = 2;
        default: ms = 0;
      endcase
      if (proc_reset) begin ms = 0; last = 1; end
    end

    // Monitor / scoreboard.
    always @(negedge clk) if (started) begin
      if (!cur_act && (mem_read || mem_write)) begin
        if (q.size() == 0) chk("strobe_without_grant", 128'({mem_read, mem_write}), 128'(0));
        else begin
          cur = q.pop_front();
          cur_act = 1;
          chk("grant_cycle", 128'(cyc), 128'(cur.cyc));
        end
      end
      if (cur_act && mem_ready) begin
        chk("ic_ready", 128'(ic_ready), 128'(!cur.d));
        chk("dc_ready", 128'(dc_ready), 128'(cur.d));
        chk("ic_rdata", ic_rdata, cur.d ? 128'(0) : mem_rdata);
        chk("dc_rdata", dc_rdata, cur.d ? mem_rdata : 128'(0));
        chk("strobe_in_ready_cycle", 128'({mem_read, mem_write}), 128'(0));
        cur_act = 0;
      end else if (cur_act) begin
        chk("mem_write", 128'(mem_write), 128'(cur.wr));
        chk("mem_read", 128'(mem_read), 128'(!cur.wr));
        chk("mem_addr", 128'(mem_addr), 128'(cur.addr));
        chk("mem_wdata", mem_wdata, cur.wdata);
        chk("ready_during_grant", 128'({ic_ready, dc_ready}), 128'(0));
        chk("rdata_during_grant", ic_rdata | dc_rdata, 128'(0));
      end else begin
        chk("idle_ready", 128'({ic_ready, dc_ready}), 128'(0));
        chk("idle_rdata", ic_rdata | dc_rdata, 128'(0));
        chk("idle_mem_addr", 128'(mem_addr), 128'(0));
        chk("idle_mem_wdata", mem_wdata, 128'(0));
      end
      if (proc_reset) cur_act = 0;
    end
  end

  initial begin
    wait (done_cnt == 2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sits directly downstream of the instruction cache and the data cache.
- Multiplexes both caches' block-level memory interfaces onto the single off-chip memory port.
- Grants one requester at a time, holds the grant until the memory returns mem_ready, and routes read data and ready back to the granted cache.
- Each cache sees its side as a private memory with an unchanged protocol.

Parameters:
- ADDR_W, 28, block address width (word address / 4).
- DATA_W, 128, block data width.
- FIXED_PRIO, 0, 0 = round-robin between I and D; 1 = D-cache always wins simultaneous requests.

Ports:
- clk  input  1  system clock, rising edge.
- proc_reset  input  1  synchronous, active-high reset.
- ic_read  input  1  I-cache block read request.
- ic_write  input  1  I-cache block write request.
- ic_addr  input  ADDR_W  I-cache block address.
- ic_wdata  input  DATA_W  I-cache write block.
- ic_rdata  output  DATA_W  read block to I-cache.
- ic_ready  output  1  I-cache transfer complete, 1-cycle pulse.
- dc_read  input  1  D-cache block read request.
- dc_write  input  1  D-cache block write request.
- dc_addr  input  ADDR_W  D-cache block address.
- dc_wdata  input  DATA_W  D-cache write block.
- dc_rdata  output  DATA_W  read block to D-cache.
- dc_ready  output  1  D-cache transfer complete, 1-cycle pulse.
- mem_read  output  1  memory read strobe.
- mem_write  output  1  memory write strobe.
- mem_addr  output  ADDR_W  memory block address.
- mem_wdata  output  DATA_W  memory write block.
- mem_rdata  input  DATA_W  memory read block, valid when mem_ready=1.
- mem_ready  input  1  memory transfer complete, 1-cycle pulse.

Behaviour:
- Clock and reset: one clock (clk). proc_reset is synchronous and active-high.
- States: IDLE, GNT_I, GNT_D, RELEASE.
- On reset:
  - state = IDLE, last_grant = D (so I wins the first tie), latched op/addr/wdata = 0.
  - All outputs 0 in the cycle after reset is sampled.
  - Reset mid-transfer abandons the access; any later mem_ready is ignored while in IDLE.
- Request definitions: req_i = ic_read|ic_write; req_d = dc_read|dc_write.
- IDLE arbitration:
  - Only one request: grant it.
  - Both, FIXED_PRIO=1: grant D.
  - Both, FIXED_PRIO=0: grant the requester not equal to last_grant.
- Grant latching:
  - On grant, latch op (write if client write=1, else read; write wins if both asserted), addr and wdata.
  - Update last_grant and move to GNT_x the next cycle.
  - Client inputs are not re-sampled during GNT_x.
- GNT_x outputs:
  - mem_read = latched_read & ~mem_ready; mem_write = latched_write & ~mem_ready. The strobe drops combinationally in the ready cycle.
  - mem_addr / mem_wdata = latched values, held stable for the whole grant.
- Completion:
  - In GNT_x with mem_ready=1: x_ready=1 for that cycle only, x_rdata = mem_rdata combinationally in that cycle.
  - Next state = RELEASE.
  - The non-granted client's ready and rdata stay 0.
- RELEASE:
  - One idle cycle, mem strobes 0, no grant, so the client can retire or drop its request.
  - Next state is always IDLE.
- Minimum turnaround: request → grant in 1 cycle, so the first mem strobe appears in the cycle after the request is seen. Back-to-back transfers have 2 dead cycles (RELEASE + IDLE).
- Outside the ready cycle: ic_rdata and dc_rdata = 0; mem_addr and mem_wdata = 0 in IDLE/RELEASE.
- Starvation: with FIXED_PRIO=0 and both requesting continuously, grants strictly alternate I, D, I, D.
- mem_ready in IDLE or RELEASE: ignored; no client ready is produced.
- Client deasserting its request mid-grant: the transfer still completes; ready is still pulsed.

Test Plan:
- Reset, then ic_read=1, ic_addr=28'h0000010 → next cycle mem_read=1, mem_addr=28'h0000010. Memory gives mem_ready after 4 cycles with mem_rdata=128'hA5 → ic_ready=1 and ic_rdata=128'hA5 in that same cycle only; mem_read=0 in that cycle.
- dc_write=1, dc_addr=28'h0000123, dc_wdata=128'hDEAD_BEEF → mem_write=1 with that addr/data held stable until mem_ready. Then dc_ready pulses once, ic_ready stays 0.
- Both requesting from reset, FIXED_PRIO=0 → grant order I, D, I, D over 4 transfers. With FIXED_PRIO=1 → D every time while dc_read is held.
- ic_read held through completion → after ic_ready: RELEASE cycle with mem_read=0, IDLE cycle, then re-grant of I. Confirms the 2-cycle gap.
- proc_reset asserted 2 cycles into GNT_D → mem_read/mem_write=0 next cycle, state IDLE. A mem_ready pulse 1 cycle later → no dc_ready, no ic_ready.
- dc_read and dc_write both 1 → a write is issued (mem_write=1, mem_read=0).
